// File: rtl/img_rom_scan_ctrl_if.sv
// ROM read port plus pixel stream of img_rom_scan_ctrl, bundled with controller and sink views.
interface img_rom_scan_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
);
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;

    modport master (
        output rom_en, rom_addr, m_valid, m_data, m_sof, m_eol, m_eof,
        input  rom_data, m_ready
    );

    modport slave (
        input  rom_en, rom_addr, m_valid, m_data, m_sof, m_eol, m_eof,
        output rom_data, m_ready
    );
endinterface

// File: rtl/img_rom_scan_ctrl.sv
// Raster-scans an image ROM into a valid/ready pixel stream with sof/eol/eof sideband.
// Optional macro IMG_SCAN_LOOP_EN: frames repeat back-to-back until reset.
module img_rom_scan_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 125
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    img_rom_scan_ctrl_if.master bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int EW = DATA_WIDTH + 3;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_pend;
    logic [2:0]            r_pend_sb;
    logic [EW-1:0]         r_mem [0:1];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_scan_act;
    logic                  w_issue;
    logic                  w_last;
    logic [EW-1:0]         w_head;

    // {sof, eol, eof} for the pixel at (x, y)
    function automatic logic [2:0] sideband(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {(x == '0) && (y == '0), (x == X_LAST), (x == X_LAST) && (y == Y_LAST)};
    endfunction

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & bus.m_ready;
    // Occupancy once this cycle's pop and the arriving pixel settle; a new read fits if below 2.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop};
`ifdef IMG_SCAN_LOOP_EN
    assign w_scan_act = (r_state == SCAN) || (r_state == DONE);
`else
    assign w_scan_act = (r_state == SCAN);
`endif
    assign w_issue = w_scan_act && (w_occ < 3'd2);
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_head  = r_mem[r_rd_ptr];

    // Scan counters, in-flight tracking, output FIFO and frame FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_pend    <= 1'b0;
            r_pend_sb <= 3'b000;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_issue) begin
                r_pend_sb <= sideband(r_x, r_y);
                if (w_last) begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_addr <= '0;
                end else if (r_x == X_LAST) begin
                    r_x    <= '0;
                    r_y    <= r_y + YW'(1);
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end else begin
                    r_x    <= r_x + XW'(1);
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
            r_pend <= w_issue;

            if (r_pend) begin
                r_mem[r_wr_ptr] <= {r_pend_sb, bus.rom_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_occ[1:0];

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_issue && w_last) begin
`ifdef IMG_SCAN_LOOP_EN
                        r_state <= DONE;
`else
                        r_state <= DRAIN;
`endif
                    end
                end
                DRAIN: begin
                    if (w_occ == 3'd0) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
`ifdef IMG_SCAN_LOOP_EN
                    // Next frame is already issuing here; only a one-pixel image ends again at once.
                    if (w_issue && w_last) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= SCAN;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign bus.rom_en   = w_issue;
    assign bus.rom_addr = r_addr;
    assign bus.m_valid  = w_valid;
    assign bus.m_data   = w_valid ? w_head[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
    assign bus.m_sof    = w_valid & w_head[EW-1];
    assign bus.m_eol    = w_valid & w_head[EW-2];
    assign bus.m_eof    = w_valid & w_head[EW-3];
endmodule

// File: doc/img_rom_scan_ctrl.md
IMG_ROM_SCAN_CTRL -- requirements
Module: img_rom_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 15, ROM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-003 The block SHALL have parameter IMG_W, default 128, pixels per line.
REQ-004 The block SHALL have parameter IMG_H, default 125, lines per frame; IMG_W*IMG_H SHALL be no more than 2^ADDR_WIDTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: frame request pulse, sampled only in IDLE.
REQ-008 The block SHALL have ports busy, output, 1 bit, and done, output, 1 bit: busy is high outside IDLE; done is a one-cycle end-of-frame pulse.
REQ-009 The block SHALL have ports rom_en, output, 1 bit, and rom_addr, output, ADDR_WIDTH bits: the ROM read request.
REQ-010 The block SHALL have port rom_data, input, DATA_WIDTH bits: the ROM read data, valid exactly 1 cycle after a cycle with rom_en high.
REQ-011 The block SHALL have ports m_valid, output, 1 bit; m_ready, input, 1 bit; and m_data, output, DATA_WIDTH bits: the pixel stream.
REQ-012 The block SHALL have ports m_sof, m_eol and m_eof, outputs, 1 bit each: sideband qualified by m_valid.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SCAN, DRAIN and DONE.
REQ-014 IDLE->SCAN on start=1; SCAN->DRAIN after the read for address IMG_W*IMG_H-1 is issued; DRAIN->DONE when the buffer is empty and no read is in flight; DONE->IDLE after 1 cycle, with done=1 in that cycle.
REQ-015 Reads SHALL be issued in raster order, rom_addr = y*IMG_W + x, starting at 0 and incrementing by 1 per issued read.
REQ-016 A 2-entry output FIFO SHALL hold returned pixels; rom_en SHALL be high in SCAN only when (FIFO occupancy + reads in flight) < 2, so no returned pixel is ever dropped.
REQ-017 A transfer SHALL occur on a rising edge where m_valid=1 and m_ready=1.
REQ-018 While m_valid=1 and m_ready=0, m_data and all sideband signals SHALL be held stable.
REQ-019 Latency: with start sampled at edge N and m_ready held at 1, rom_en=1 with addr 0 SHALL occur after edge N, and m_valid=1 with pixel 0 after edge N+2.
REQ-020 Throughput: with m_ready held at 1, the block SHALL sustain 1 pixel per cycle with no bubbles within a frame.
REQ-021 m_sof SHALL be 1 on pixel (0,0) only; m_eol SHALL be 1 on x=IMG_W-1; m_eof SHALL be 1 on the last pixel, together with m_eol.
REQ-022 The x and y counters SHALL wrap x at IMG_W-1 -> 0 with y incremented; the sideband SHALL be computed from the counters of the issued read and carried through the FIFO alongside its pixel.
REQ-023 Outside IDLE, start SHALL be ignored; it is neither queued nor restarts the frame.
REQ-024 A start arriving in the same cycle as done SHALL be ignored; a new frame needs start in IDLE.
REQ-025 With m_ready held at 0, the block SHALL issue at most 2 reads and then stall with rom_addr held.

Reset
REQ-026 When rst=1 at a rising edge, the FSM SHALL go to IDLE, the FIFO and in-flight count SHALL be cleared, and counters SHALL be set to 0, regardless of state or rom_data.
REQ-027 Reset values: busy=0, done=0, rom_en=0, rom_addr=0, m_valid=0, m_data=0, m_sof=0, m_eol=0, m_eof=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; rom_data returning after the reset SHALL be discarded.

Configuration
REQ-029 Macro IMG_SCAN_LOOP_EN, when defined, SHALL make DONE go directly to SCAN with counters reset, so frames repeat back-to-back; done pulses once per frame; the block stays busy until rst; and m_sof on the next frame follows m_eof with no gap when m_ready=1.
REQ-030 When IMG_SCAN_LOOP_EN is undefined, exactly one frame SHALL be produced per accepted start, as REQ-014.

Verification
REQ-031 Case IMG_W=4, IMG_H=2 (ROM holding data = addr): start with m_ready=1 -> pixels 0..7 on 8 consecutive cycles from edge N+2; sof on 0; eol on 3 and 7; eof on 7; done once; busy back to 0.
REQ-032 Case m_ready=0 for 10 cycles after start -> exactly 2 rom_en pulses and m_data=0 held; then m_ready=1 -> the stream completes in order with no loss or duplication.
REQ-033 Case random m_ready with 50% duty, default size -> 16000 pixels in order with data = ROM contents and sideband correct; the scoreboard matches the full frame.
REQ-034 Case rst pulsed at pixel 5 of frame -> all outputs at reset values the next cycle; a subsequent start streams from pixel 0 with no stale data.
REQ-035 Case start pulsed during SCAN and in the done cycle -> ignored; exactly one frame is output.
REQ-036 Case IMG_SCAN_LOOP_EN defined, 4x2 image -> two consecutive frames 0..7, 0..7 with no gap and done pulsing twice.
